// File: rtl/writeback_ctrl.sv
// Write-back controller: takes one execute result at a time, waits for load data
// when needed, and drives a single register-file write per instruction.
module writeback_ctrl #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [XLEN-1:0]       ex_result,
  input  logic                  ex_is_load,
  input  logic [2:0]            ex_funct3,
  input  logic [1:0]            ex_addr_lo,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  output logic                  rf_write_enable,
  output logic [REG_ADDR_W-1:0] rf_dest,
  output logic [XLEN-1:0]       rf_data,
  output logic                  wb_done,
  output logic                  load_err,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } state_t;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  state_t                  state, state_next;
  logic [REG_ADDR_W-1:0]   rd_q;
  logic [XLEN-1:0]         data_q;
  logic                    is_load_q;
  logic [2:0]              funct3_q;
  logic [1:0]              addr_lo_q;
  logic                    err_q;

  function automatic logic load_fault(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_LB, F3_LBU: load_fault = 1'b0;
      F3_LH, F3_LHU: load_fault = addr_lo[0];
      F3_LW:         load_fault = (addr_lo != 2'd0);
      default:       load_fault = 1'b1;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [2:0]  funct3,
                                                  input logic [1:0]  addr_lo,
                                                  input logic [31:0] rdata);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    // Size casts of signed operands sign-extend; unsigned ones zero-extend.
    case (funct3)
      F3_LB:   load_extend = XLEN'($signed(byte_sel));
      F3_LBU:  load_extend = XLEN'(byte_sel);
      F3_LH:   load_extend = XLEN'($signed(half_sel));
      F3_LHU:  load_extend = XLEN'(half_sel);
      F3_LW:   load_extend = XLEN'(rdata);
      default: load_extend = '0;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rd_q      <= '0;
      data_q    <= '0;
      is_load_q <= 1'b0;
      funct3_q  <= '0;
      addr_lo_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && ex_valid) begin
        rd_q      <= ex_rd;
        data_q    <= ex_result;
        is_load_q <= ex_is_load;
        funct3_q  <= ex_funct3;
        addr_lo_q <= ex_addr_lo;
        err_q     <= 1'b0;
      end
      if (state == WAIT_MEM && mem_rvalid) begin
        data_q <= load_extend(funct3_q, addr_lo_q, mem_rdata);
        err_q  <= load_fault(funct3_q, addr_lo_q);
      end
    end
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_next      = state;
    ex_ready        = 1'b0;
    rf_write_enable = 1'b0;
    wb_done         = 1'b0;
    load_err        = 1'b0;
    case (state)
      IDLE: begin
        ex_ready = 1'b1;
        if (ex_valid) state_next = ex_is_load ? WAIT_MEM : WRITE;
      end
      WAIT_MEM: begin
        if (mem_rvalid) state_next = WRITE;
      end
      WRITE: begin
        rf_write_enable = (rd_q != '0) && !(is_load_q && err_q);
        wb_done         = 1'b1;
        load_err        = is_load_q && err_q;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign rf_dest = rd_q;
  assign rf_data = data_q;

endmodule

// File: tb/tb_writeback_ctrl.sv
// Directed bench for writeback_ctrl: ALU writes, x0 suppression, load extension,
// load faults, reset during a transaction and handshake ordering.
module tb_writeback_ctrl;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic        ex_is_load;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_write_enable;
  logic [4:0]  rf_dest;
  logic [31:0] rf_data;
  logic        wb_done;
  logic        load_err;
  logic        busy;

  int vectors;
  int miscompares;

  writeback_ctrl #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .ex_valid        (ex_valid),
    .ex_ready        (ex_ready),
    .ex_rd           (ex_rd),
    .ex_result       (ex_result),
    .ex_is_load      (ex_is_load),
    .ex_funct3       (ex_funct3),
    .ex_addr_lo      (ex_addr_lo),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata),
    .rf_write_enable (rf_write_enable),
    .rf_dest         (rf_dest),
    .rf_data         (rf_data),
    .wb_done         (wb_done),
    .load_err        (load_err),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ex_valid = 1'b0; ex_rd = '0; ex_result = '0; ex_is_load = 1'b0;
    ex_funct3 = '0; ex_addr_lo = '0; mem_rvalid = 1'b0; mem_rdata = 32'h80F17F01;
    tick(); tick();
    reset = 1'b0;
    vectors++;
    if (ex_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ex_ready: got %b expected 1", ex_ready); end
    vectors++;
    if ({rf_write_enable, wb_done, load_err, busy} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_strobes: got we/done/err/busy=%b expected 0000", {rf_write_enable, wb_done, load_err, busy});
    end
    vectors++;
    if (rf_dest !== 5'd0 || rf_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_dest_data: got dest=%0d data=%h expected 0/00000000", rf_dest, rf_data);
    end
  endtask

  task automatic test_alu_write();
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = 5'd5; ex_result = 32'hDEADBEEF;
    tick();
    ex_valid = 1'b0;
    vectors++;
    if (ex_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL alu_ready_busy: got ready=%b busy=%b expected 0/1", ex_ready, busy);
    end
    vectors++;
    if (rf_write_enable !== 1'b1 || wb_done !== 1'b1 || load_err !== 1'b0) begin
      miscompares++;
      $display("FAIL alu_strobes: got we=%b done=%b err=%b expected 1/1/0", rf_write_enable, wb_done, load_err);
    end
    vectors++;
    if (rf_dest !== 5'd5 || rf_data !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL alu_dest_data: got %0d/%h expected 5/deadbeef", rf_dest, rf_data);
    end
    tick();
    vectors++;
    if (ex_ready !== 1'b1 || rf_write_enable !== 1'b0 || wb_done !== 1'b0) begin
      miscompares++;
      $display("FAIL alu_return_idle: got ready=%b we=%b done=%b expected 1/0/0", ex_ready, rf_write_enable, wb_done);
    end
  endtask

  task automatic test_x0_suppress();
    int we_count;
    int done_count;
    we_count = 0; done_count = 0;
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = 5'd0; ex_result = 32'h00001234;
    tick();
    ex_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rf_write_enable === 1'b1) we_count++;
      if (wb_done === 1'b1) done_count++;
      tick();
    end
    vectors++;
    if (we_count != 0) begin miscompares++; $display("FAIL x0_we: got %0d strobes expected 0", we_count); end
    vectors++;
    if (done_count != 1) begin miscompares++; $display("FAIL x0_done: got %0d pulses expected 1", done_count); end
  endtask

  // Load with mem_rvalid sampled three edges after acceptance.
  task automatic run_load(input string name, input logic [2:0] f3, input logic [1:0] lo,
                          input logic [31:0] exp_data, input logic exp_err);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd7; ex_funct3 = f3; ex_addr_lo = lo;
    ex_result = 32'h5555AAAA; mem_rvalid = 1'b0;
    tick();
    ex_valid = 1'b0;
    tick(); tick();
    vectors++;
    if (busy !== 1'b1 || rf_write_enable !== 1'b0 || wb_done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_wait: got busy=%b we=%b done=%b expected 1/0/0", name, busy, rf_write_enable, wb_done);
    end
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    vectors++;
    if (rf_write_enable !== !exp_err || wb_done !== 1'b1 || load_err !== exp_err) begin
      miscompares++;
      $display("FAIL %s_strobes: got we=%b done=%b err=%b expected %b/1/%b",
               name, rf_write_enable, wb_done, load_err, !exp_err, exp_err);
    end
    if (!exp_err) begin
      vectors++;
      if (rf_dest !== 5'd7 || rf_data !== exp_data) begin
        miscompares++; $display("FAIL %s_data: got %0d/%h expected 7/%h", name, rf_dest, rf_data, exp_data);
      end
    end
    tick();
    vectors++;
    if (ex_ready !== 1'b1 || rf_write_enable !== 1'b0 || load_err !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle: got ready=%b we=%b err=%b expected 1/0/0", name, ex_ready, rf_write_enable, load_err);
    end
  endtask

  task automatic test_load_extend();
    mem_rdata = 32'h80F17F01;
    run_load("lb1",  3'd0, 2'd1, 32'h0000007F, 1'b0);
    run_load("lb2",  3'd0, 2'd2, 32'hFFFFFFF1, 1'b0);
    run_load("lbu3", 3'd4, 2'd3, 32'h00000080, 1'b0);
    run_load("lh2",  3'd1, 2'd2, 32'hFFFF80F1, 1'b0);
    run_load("lhu0", 3'd5, 2'd0, 32'h00007F01, 1'b0);
    run_load("lw0",  3'd2, 2'd0, 32'h80F17F01, 1'b0);
  endtask

  task automatic test_load_errors();
    run_load("lw_mis",  3'd2, 2'd2, 32'h0, 1'b1);
    run_load("lh_mis",  3'd1, 2'd3, 32'h0, 1'b1);
    run_load("f3_ill3", 3'd3, 2'd0, 32'h0, 1'b1);
    run_load("f3_ill6", 3'd6, 2'd0, 32'h0, 1'b1);
  endtask

  // mem_rvalid coinciding with acceptance must not complete the load.
  task automatic test_rvalid_early();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd9; ex_funct3 = 3'd2; ex_addr_lo = 2'd0;
    mem_rdata = 32'h11223344; mem_rvalid = 1'b1;
    tick();
    ex_valid = 1'b0; mem_rvalid = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b1 || rf_write_enable !== 1'b0 || wb_done !== 1'b0) begin
      miscompares++;
      $display("FAIL early_rvalid: got busy=%b we=%b done=%b expected 1/0/0", busy, rf_write_enable, wb_done);
    end
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    vectors++;
    if (rf_write_enable !== 1'b1 || rf_data !== 32'h11223344) begin
      miscompares++; $display("FAIL early_write: got we=%b data=%h expected 1/11223344", rf_write_enable, rf_data);
    end
    tick();
    mem_rdata = 32'h80F17F01;
  endtask

  task automatic test_reset_mid();
    int stray;
    stray = 0;
    // Reset while waiting for load data, then a stale mem_rvalid.
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd12; ex_funct3 = 3'd2; ex_addr_lo = 2'd0;
    tick();
    ex_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (ex_ready !== 1'b1 || busy !== 1'b0 || rf_dest !== 5'd0 || rf_data !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_wait_state: got ready=%b busy=%b dest=%0d data=%h expected 1/0/0/0", ex_ready, busy, rf_dest, rf_data);
    end
    tick();
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rf_write_enable !== 1'b0 || wb_done !== 1'b0 || busy !== 1'b0) stray++;
      tick();
    end
    vectors++;
    if (stray != 0) begin miscompares++; $display("FAIL rst_stale_rvalid: got %0d active cycles expected 0", stray); end

    // Reset while in WRITE discards the pending write.
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = 5'd13; ex_result = 32'hCAFEF00D;
    tick();
    ex_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (rf_write_enable !== 1'b0 || wb_done !== 1'b0 || busy !== 1'b0 || rf_dest !== 5'd0) begin
      miscompares++;
      $display("FAIL rst_write_state: got we=%b done=%b busy=%b dest=%0d expected 0/0/0/0", rf_write_enable, wb_done, busy, rf_dest);
    end

    // Reset and ex_valid together: nothing latched.
    reset = 1'b1; ex_valid = 1'b1; ex_rd = 5'd14; ex_result = 32'h0BADF00D;
    tick();
    reset = 1'b0; ex_valid = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b0 || rf_write_enable !== 1'b0 || rf_dest !== 5'd0 || rf_data !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_with_valid: got busy=%b we=%b dest=%0d data=%h expected 0/0/0/0", busy, rf_write_enable, rf_dest, rf_data);
    end
  endtask

  task automatic test_back_to_back();
    // ex_valid held high; inputs changed while in WRITE must not be latched.
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = 5'd3; ex_result = 32'hAAAA0003;
    tick();
    ex_rd = 5'd4; ex_result = 32'hBBBB0004;
    vectors++;
    if (rf_write_enable !== 1'b1 || rf_dest !== 5'd3 || rf_data !== 32'hAAAA0003) begin
      miscompares++;
      $display("FAIL b2b_first: got we=%b %0d/%h expected 1 3/aaaa0003", rf_write_enable, rf_dest, rf_data);
    end
    tick();
    vectors++;
    if (ex_ready !== 1'b1 || rf_write_enable !== 1'b0 || rf_dest !== 5'd3) begin
      miscompares++;
      $display("FAIL b2b_gap: got ready=%b we=%b dest=%0d expected 1/0/3", ex_ready, rf_write_enable, rf_dest);
    end
    tick();
    vectors++;
    if (rf_write_enable !== 1'b1 || rf_dest !== 5'd4 || rf_data !== 32'hBBBB0004) begin
      miscompares++;
      $display("FAIL b2b_second: got we=%b %0d/%h expected 1 4/bbbb0004", rf_write_enable, rf_dest, rf_data);
    end

    // Load held in WAIT_MEM while an ALU result waits upstream.
    ex_is_load = 1'b1; ex_rd = 5'd7; ex_funct3 = 3'd4; ex_addr_lo = 2'd2; mem_rdata = 32'h80F17F01;
    tick();
    tick();
    ex_is_load = 1'b0; ex_rd = 5'd6; ex_result = 32'hCCCC0006;
    tick(); tick();
    vectors++;
    if (busy !== 1'b1 || ex_ready !== 1'b0 || rf_dest !== 5'd7) begin
      miscompares++;
      $display("FAIL b2b_wait_hold: got busy=%b ready=%b dest=%0d expected 1/0/7", busy, ex_ready, rf_dest);
    end
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    vectors++;
    if (rf_write_enable !== 1'b1 || rf_dest !== 5'd7 || rf_data !== 32'h000000F1) begin
      miscompares++;
      $display("FAIL b2b_load_write: got we=%b %0d/%h expected 1 7/000000f1", rf_write_enable, rf_dest, rf_data);
    end
    tick();
    tick();
    ex_valid = 1'b0;
    vectors++;
    if (rf_write_enable !== 1'b1 || rf_dest !== 5'd6 || rf_data !== 32'hCCCC0006) begin
      miscompares++;
      $display("FAIL b2b_after_load: got we=%b %0d/%h expected 1 6/cccc0006", rf_write_enable, rf_dest, rf_data);
    end
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_alu_write();
    test_x0_suppress();
    test_load_extend();
    test_load_errors();
    test_rvalid_early();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/writeback_ctrl.md
# writeback_ctrl

Write-back controller that sits directly upstream of the ID-stage register file and drives its write port (write enable, destination, write data). It accepts one completed instruction result at a time from execute over a valid/ready handshake. For loads it waits for memory read data, then byte-selects and sign/zero-extends it. It issues exactly one register-file write per instruction, suppressing writes to x0 and to faulting loads.

## Interface
Parameters:
- XLEN, 32, datapath width; must be ≥ 32.
- REG_ADDR_W, 5, register-file destination index width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- ex_valid  in  1  execute presents a result.
- ex_ready  out  1  controller can accept a result this cycle.
- ex_rd  in  REG_ADDR_W  destination register.
- ex_result  in  XLEN  ALU result; ignored for loads.
- ex_is_load  in  1  instruction is a load.
- ex_funct3  in  3  load type: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
- ex_addr_lo  in  2  low two bits of the load address.
- mem_rvalid  in  1  memory read data valid.
- mem_rdata  in  32  memory read word.
- rf_write_enable  out  1  register-file write strobe.
- rf_dest  out  REG_ADDR_W  register-file destination.
- rf_data  out  XLEN  register-file write data.
- wb_done  out  1  one-cycle pulse; instruction retired.
- load_err  out  1  one-cycle pulse; load faulted, no write.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states are IDLE, WAIT_MEM and WRITE.
- **IDLE**
  - ex_ready = 1.
  - On ex_valid, latch ex_rd, ex_is_load, ex_funct3, ex_addr_lo and ex_result.
  - Next state is WAIT_MEM for a load, otherwise WRITE.
  - With ex_valid low, stay in IDLE.
- **WAIT_MEM**
  - ex_ready = 0.
  - On mem_rvalid, compute load data into the data register and go to WRITE; otherwise hold.
- **WRITE**
  - ex_ready = 0.
  - rf_write_enable = 1 only if latched rd ≠ 0 and there is no load error.
  - wb_done = 1.
  - load_err = 1 if there is a load error.
  - Next state is always IDLE.
- **Load data**, with b = 8·addr_lo and h = 16·addr_lo[1]:
  - LB: sign-extend mem_rdata[b+7:b] to XLEN.
  - LBU: zero-extend mem_rdata[b+7:b] to XLEN.
  - LH: sign-extend mem_rdata[h+15:h].
  - LHU: zero-extend mem_rdata[h+15:h].
  - LW: mem_rdata, zero-extended to XLEN when XLEN > 32 (RV32 core).
- **Load error** is raised for:
  - LH or LHU with addr_lo[0] = 1;
  - LW with addr_lo ≠ 0;
  - funct3 ∈ {3, 6, 7}.
- On a load error, mem_rvalid is still awaited, then WRITE pulses load_err and wb_done with no write.
- rf_dest and rf_data are registered outputs holding the latched rd and data. They keep their value outside WRITE, and their value is meaningful only when rf_write_enable = 1.
- mem_rvalid outside WAIT_MEM is ignored.
- ex_valid outside IDLE is ignored; execute must hold its result until it sees ex_ready.

## Timing
- Reset values:
  - state = IDLE;
  - rf_write_enable, wb_done, load_err and busy = 0;
  - rf_dest = 0 and rf_data = 0;
  - ex_ready = 1 in the first cycle after reset.
- ALU result accepted at edge N: write strobe during cycle N+1, back in IDLE (ex_ready = 1) at cycle N+2. Throughput is one ALU result per 2 cycles.
- Load accepted at edge N, mem_rvalid sampled high at edge M ≥ N+1: write strobe during cycle M+1, idle at M+2.
- mem_rvalid asserted in the same cycle as load acceptance is not consumed; it must arrive in WAIT_MEM.
- rf_write_enable, wb_done and load_err are each exactly one cycle wide and occur only in WRITE.
- Reset asserted in any state, including WAIT_MEM or WRITE:
  - the next edge returns to IDLE with all outputs at their reset values;
  - the pending write is discarded;
  - a later stale mem_rvalid is ignored.
- Simultaneous reset and ex_valid: reset wins and nothing is latched.

## Test plan
- **ALU write:** reset, then ex_valid with rd = 5, ex_result = 0xDEADBEEF → ex_ready low for 1 cycle; one-cycle rf_write_enable with rf_dest = 5, rf_data = 0xDEADBEEF, wb_done = 1; ex_ready high again 2 cycles after acceptance.
- **x0 suppression:** ALU result with rd = 0, data 0x1234 → rf_write_enable stays 0, wb_done pulses once.
- **Load extension:** mem_rdata = 0x80F17F01 with a 3-cycle memory delay:
  - LB addr_lo = 1 → 0x0000007F;
  - LB addr_lo = 2 → 0xFFFFFFF1;
  - LBU addr_lo = 3 → 0x00000080;
  - LH addr_lo = 2 → 0xFFFF80F1;
  - LHU addr_lo = 0 → 0x00007F01;
  - LW → 0x80F17F01.
  
  Each write occurs exactly one cycle after mem_rvalid.
- **Misaligned and illegal loads:** LW with addr_lo = 2, LH with addr_lo = 3, and funct3 = 3 → after mem_rvalid, load_err and wb_done pulse together with rf_write_enable = 0.
- **Reset mid-load:** accept LW, assert reset in WAIT_MEM, then mem_rvalid 2 cycles later → no write, no wb_done, ex_ready = 1, busy = 0.
- **Handshake ordering:** hold ex_valid continuously with two different results → the second is accepted only in IDLE, writes occur in order, and ex_valid asserted during WAIT_MEM or WRITE is not latched.
